// File: rtl/logic16_pipe_if.sv
// Operand/result handshake bundle for logic16_pipe.
// Flag signals exist only when LOGIC16_PIPE_FLAGS_EN is defined.
interface logic16_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [15:0]      out_count;
`ifdef LOGIC16_PIPE_FLAGS_EN
    logic             out_zero;
    logic             out_neg;

    modport master (
        output in_valid, op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out, out_count, out_zero, out_neg
    );
    modport slave (
        input  in_valid, op, in_a, in_b, out_ready,
        output in_ready, out_valid, out, out_count, out_zero, out_neg
    );
`else
    modport master (
        output in_valid, op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out, out_count
    );
    modport slave (
        input  in_valid, op, in_a, in_b, out_ready,
        output in_ready, out_valid, out, out_count
    );
`endif
endinterface

// File: rtl/logic16_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control and a consume counter.
// Define LOGIC16_PIPE_FLAGS_EN to carry zero/negative flags alongside each result.
module logic16_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    logic16_pipe_if.slave bus
);
`ifdef LOGIC16_PIPE_FLAGS_EN
    localparam int FW = 2;
`else
    localparam int FW = 0;
`endif
    // Flags ride in the top bits of each stage word: {neg, zero, data}.
    localparam int DW = WIDTH + FW;

    logic [STAGES-1:0]         valid_q, valid_d, adv;
    logic [STAGES-1:0][DW-1:0] data_q, data_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [WIDTH-1:0]          res;
    logic [DW-1:0]             res_word;
    logic                      accept, consume;

    always_comb begin
        case (bus.op)
            3'd0:    res = ~bus.in_a;
            3'd1:    res = bus.in_a & bus.in_b;
            3'd2:    res = bus.in_a | bus.in_b;
            3'd3:    res = bus.in_a ^ bus.in_b;
            3'd4:    res = ~(bus.in_a & bus.in_b);
            3'd5:    res = ~(bus.in_a | bus.in_b);
            3'd6:    res = ~(bus.in_a ^ bus.in_b);
            default: res = bus.in_a;
        endcase
    end

`ifdef LOGIC16_PIPE_FLAGS_EN
    assign res_word = {res[WIDTH-1], ~|res, res};
`else
    assign res_word = res;
`endif

    // A stage advances when some slot above it is empty or the consumer takes
    // the head; scanning top-down keeps the ready chain free of loops.
    always_comb begin : adv_scan
        logic hole;
        adv  = '0;
        hole = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = valid_q[k] && hole;
            hole   = hole || !valid_q[k];
        end
    end

    assign bus.in_ready = !valid_q[0] || adv[0];
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = valid_q[STAGES-1] && bus.out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d[0] = 1'b1;
            data_d[0]  = res_word;
        end else if (adv[0]) begin
            valid_d[0] = 1'b0;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k-1]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = data_q[k-1];
            end else if (adv[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        cnt_d = cnt_q + 16'(consume);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out       = data_q[STAGES-1][WIDTH-1:0];
    assign bus.out_count = cnt_q;
`ifdef LOGIC16_PIPE_FLAGS_EN
    assign bus.out_zero  = data_q[STAGES-1][WIDTH];
    assign bus.out_neg   = data_q[STAGES-1][WIDTH+1];
`endif
endmodule

// File: tb/tb_logic16_pipe.sv
// Directed bench for logic16_pipe (WIDTH=16, STAGES=2): ops, backpressure,
// randomized flow against a scoreboard, async reset, and counter wrap.
module tb_logic16_pipe;
    localparam int W = 16;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic16_pipe_if #(.WIDTH(W)) bus ();
    logic16_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // One beat through an empty pipe with out_ready held high.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = op; bus.in_a = a; bus.in_b = b; bus.out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        chk({tag, "_early"}, bus.out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_data"}, bus.out, exp);
`ifdef LOGIC16_PIPE_FLAGS_EN
        chk({tag, "_zero"}, bus.out_zero, exp == 16'h0);
        chk({tag, "_neg"}, bus.out_neg, exp[15]);
`endif
    endtask

    task automatic stream(input string tag, input int nbeats, input int hold, input bit rnd);
        logic [15:0] expq[$];
        logic [2:0]  op;
        logic [15:0] a, b, prev_out;
        int sent, got, cyc;
        bit have, stalled;
        sent = 0; got = 0; cyc = 0; have = 0; stalled = 0; prev_out = '0;
        op = '0; a = '0; b = '0;
        while (got < nbeats && cyc < 20000) begin
            @(negedge clk);
            if (!have && sent < nbeats) begin
                op = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom); have = 1;
            end
            bus.in_valid  = have && (!rnd || $urandom_range(0, 9) < 7);
            bus.op = op; bus.in_a = a; bus.in_b = b;
            bus.out_ready = (cyc >= hold) && (!rnd || $urandom_range(0, 9) < 7);
            #1;
            if (stalled) begin
                chk({tag, "_stall_valid"}, bus.out_valid, 1);
                chk({tag, "_stall_data"}, bus.out, prev_out);
            end
            if (hold > 0 && cyc == hold - 1) begin
                chk({tag, "_full_in_ready"}, bus.in_ready, 0);
                chk({tag, "_accepts_when_full"}, sent, S);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk({tag, "_outstanding"}, expq.size() != 0, 1);
                if (expq.size() != 0) chk({tag, "_order"}, bus.out, expq.pop_front());
                got++;
            end
            stalled  = bus.out_valid && !bus.out_ready;
            prev_out = bus.out;
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(model(op, a, b));
                sent++; have = 0;
            end
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_timeout"}, cyc < 20000, 1);
        chk({tag, "_drained"}, expq.size(), 0);
        chk({tag, "_no_extra"}, bus.out_valid, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n, cyc;
        bus.in_valid = 1'b0; bus.op = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_count", bus.out_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        do_op("not25",   3'd0, 16'd25,   16'h1234, 16'hFFE6);
        do_op("not4181", 3'd0, 16'd4181, 16'h0000, 16'hEFAA);
        do_op("and",  3'd1, 16'h0F0F, 16'h00FF, 16'h000F);
        do_op("or",   3'd2, 16'h0F0F, 16'h00FF, 16'h0FFF);
        do_op("xor",  3'd3, 16'h0F0F, 16'h00FF, 16'h0FF0);
        do_op("nand", 3'd4, 16'h0F0F, 16'h00FF, 16'hFFF0);
        do_op("nor",  3'd5, 16'h0F0F, 16'h00FF, 16'hF000);
        do_op("xnor", 3'd6, 16'h0F0F, 16'h00FF, 16'hF00F);
        do_op("pass", 3'd7, 16'h0F0F, 16'h00FF, 16'h0F0F);
        do_op("pass0", 3'd7, 16'h0000, 16'hFFFF, 16'h0000);
        do_op("not0",  3'd0, 16'h0000, 16'h0000, 16'hFFFF);
        @(negedge clk);
        chk("count_after_ops", bus.out_count, 11);

        pulse_reset();
        stream("bp", 10, 6, 1'b0);
        chk("bp_count", bus.out_count, 10);

        stream("rnd", 1000, 0, 1'b1);
        chk("rnd_count", bus.out_count, 1010);

        // Two beats in flight, then reset between edges.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'd7; bus.in_a = 16'h1234; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_a = 16'h5678;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("mid_out_valid_pre", bus.out_valid, 1);
        chk("mid_out_pre", bus.out, 16'h1234);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out", bus.out, 0);
        chk("mid_rst_count", bus.out_count, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
`ifdef LOGIC16_PIPE_FLAGS_EN
        chk("mid_rst_zero", bus.out_zero, 0);
        chk("mid_rst_neg", bus.out_neg, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", bus.out_valid, 0);
        end

        // Full-throughput run long enough to wrap the consume counter.
        bus.in_valid = 1'b1; bus.op = 3'd7; bus.in_a = 16'hA5A5; bus.out_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 65536 && cyc < 70000) begin
            @(negedge clk);
            #1;
            if (n == 65535) chk("wrap_count_ffff", bus.out_count, 16'hFFFF);
            if (bus.out_valid && bus.out_ready) n++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("wrap_timeout", cyc < 70000, 1);
        chk("wrap_count_zero", bus.out_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/logic16_pipe.md
# logic16_pipe

Parametrised, pipelined bitwise logic unit that generalises the 16-bit Not gate. It applies one of eight selectable bitwise operations to two WIDTH-bit operands and moves results through a STAGES-deep register pipeline with valid/ready flow control. It sits between operand producers (register file, test sequencer) and the ALU result path of the Hack-style datapath.

## Interface
- WIDTH, 16, operand and result width in bits (≥1).
- STAGES, 2, pipeline depth in register stages (1–4).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  unit accepts a beat this cycle.
- op  input  3  operation select, sampled with the operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B; ignored by NOT and PASS.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH  result data.
- out_count  output  16  number of results consumed, modulo 2^16.
- out_zero  output  1  result equals 0 (present only with the macro).
- out_neg  output  1  result MSB (present only with the macro).

## Operation
- Op encoding: 0 NOT a, 1 a AND b, 2 a OR b, 3 a XOR b, 4 NAND, 5 NOR, 6 XNOR, 7 PASS a. All operations are bitwise across WIDTH. There are no carries and no width growth.
- Operation is computed combinationally at acceptance and stored in stage 0. Later stages only move data.
- Accept occurs when in_valid && in_ready. Consume occurs when out_valid && out_ready.
- Each stage k holds valid_k and data_k. Stage k advances when valid_k and (stage k+1 is empty or stage k+1 advances). The last stage advances on out_ready.
- in_ready = !valid_0 || stage 0 advances. This is combinational through the chain and gives full throughput with no bubbles.
- out_valid = valid of the last stage. out = data of the last stage.
- out_count increments by 1 on each consume and wraps from 0xFFFF to 0x0000.
- A beat is never dropped or duplicated. Beats leave in acceptance order.
- out is held stable while out_valid && !out_ready.
- No state machine beyond the per-stage valid bits. A stage is EMPTY (valid=0) or FULL (valid=1). It goes EMPTY→FULL when loaded. It goes FULL→EMPTY when it advances and nothing is loaded into it. It stays FULL when it advances and is reloaded in the same cycle.

## Timing
- Reset asserted: all valid bits = 0, all data registers = 0, out = 0, out_valid = 0, out_count = 0, in_ready = 1 (combinationally, since the pipeline is empty). Reset takes effect immediately, independent of clk.
- Reset mid-operation discards all in-flight beats. No output is produced for them after reset releases.
- First accept is possible on the first rising edge after reset deasserts.
- Latency: with an empty pipe and out_ready=1, a beat accepted at edge N is visible on out after edge N+STAGES−1. At STAGES=1, the result appears directly after the accepting edge.
- Full pipe with out_ready=0: in_ready=0. Asserting out_ready gives in_ready=1 in the same cycle, so a simultaneous consume and accept is legal.
- Simultaneous accept and consume on a full pipe leaves the occupancy unchanged.
- in_valid may deassert at any time. op, in_a and in_b matter only in the accept cycle.

## Configuration
- LOGIC16_PIPE_FLAGS_EN defined: out_zero and out_neg ports exist. Both are computed at stage 0 and pipelined alongside data. Both reset to 0. Both hold with out.
- LOGIC16_PIPE_FLAGS_EN undefined: the ports and flag registers are absent. All other behaviour is identical.

## Test plan
- NOT, STAGES=2: reset, accept op=0 in_a=25 → out=16'hFFE6 (signed −26) one edge later. Then in_a=4181 → out=16'hEFAA (signed −4182).
- All ops with in_a=16'h0F0F, in_b=16'h00FF → AND 0x000F, OR 0x0FFF, XOR 0x0FF0, NAND 0xFFF0, NOR 0xF000, XNOR 0xF00F, PASS 0x0F0F.
- Backpressure: stream 10 beats with out_ready held 0 → in_ready falls after STAGES accepts. Then release out_ready → all 10 results emerge in order, out_count=10.
- Random in_valid/out_ready toggling for 1000 beats against a scoreboard → no loss, no duplication, order preserved, out stable while stalled.
- Reset mid-stream with 2 beats in flight → out_valid=0, out=0, out_count=0 immediately, without waiting for an edge. No stale beat appears after release.
- With LOGIC16_PIPE_FLAGS_EN: PASS 0 → out_zero=1, out_neg=0. NOT 0 → out=0xFFFF, out_neg=1, out_zero=0. Separately, force 65536 consumes → out_count wraps to 0.
